// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the pipeline controller.
//   state_t    - controller FSM states
//   stage_en_t - bundle of the five per-stage register load enables
//   WAIT_W     - width of the memory-wait counter
package pipe_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_en_t;

  localparam int WAIT_W = 16;

  localparam stage_en_t EN_NONE = stage_en_t'(5'b00000);
  localparam stage_en_t EN_ALL  = stage_en_t'(5'b11111);

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard/stall signals between the pipeline datapath and
// its controller.
//   Datapath -> controller : id_rs1, id_rs2, ex_rd, ex_memread, ex_redirect,
//                            imem_ready, mem_req, dmem_ready
//   Controller -> datapath : pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//                            if_id_flush, id_ex_bubble, halted, mem_timeout
// Modports: master = datapath side, slave = controller side.
interface pipeline_ctrl_if #(
  parameter int REG_ADDR_W = 5
) ();

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_memread;
  logic                  ex_redirect;
  logic                  imem_ready;
  logic                  mem_req;
  logic                  dmem_ready;

  logic                  pc_en;
  logic                  if_id_en;
  logic                  id_ex_en;
  logic                  ex_mem_en;
  logic                  mem_wb_en;
  logic                  if_id_flush;
  logic                  id_ex_bubble;
  logic                  halted;
  logic                  mem_timeout;

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_memread, ex_redirect,
           imem_ready, mem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_bubble, halted, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_memread, ex_redirect,
           imem_ready, mem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_bubble, halted, mem_timeout
  );

endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use hazard compare.
//   ex_memread, ex_rd : load in EX and its destination register
//   id_rs1, id_rs2    : sources of the instruction in ID
//   load_use          : ID must wait one cycle for the load result
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  output logic                  load_use
);

  // Register 0 is hardwired to zero, so a load targeting it never produces a
  // value worth waiting for.
  always_comb begin
    load_use = ex_memread && (ex_rd != '0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/halt controller for a 5-stage pipeline.
//   clk, arst_n  : clock (rising edge) and asynchronous active-low reset
//   bus (slave)  : hazard inputs and stage enables, see pipeline_ctrl_if
//   stall_cycles : (PIPE_CTRL_PERF_EN only) cycles with pc_en=0 in RUN/MEM_WAIT
//   flush_count  : (PIPE_CTRL_PERF_EN only) redirect flush cycles
// Optional feature macro: PIPE_CTRL_PERF_EN adds the two saturating
// performance counters and their ports.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 256,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  pipeline_ctrl_if.slave    bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
`endif
);

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_timeout_q;
  logic              load_use;
  stage_en_t         en, run_en;
  logic              flush, bubble, run_flush, run_bubble;
  logic              redirect_flush;
  logic              mem_stall;
  logic              timeout_hit;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .ex_memread (bus.ex_memread),
    .ex_rd      (bus.ex_rd),
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .load_use   (load_use)
  );

  // Next state and outputs. run_* holds the redirect > load-use > fetch-miss
  // evaluation, reused both in RUN and on the cycle a memory wait completes.
  always_comb begin
    en             = EN_NONE;
    flush          = 1'b0;
    bubble         = 1'b0;
    redirect_flush = 1'b0;
    state_next     = state;

    run_en     = EN_ALL;
    run_flush  = 1'b0;
    run_bubble = 1'b0;
    if (bus.ex_redirect) begin
      run_flush  = 1'b1;
      run_bubble = 1'b1;
    end else if (load_use) begin
      run_en.pc    = 1'b0;
      run_en.if_id = 1'b0;
      run_bubble   = 1'b1;
    end else if (!bus.imem_ready) begin
      run_en.pc = 1'b0;
      run_flush = 1'b1;
    end

    mem_stall   = (state == RUN) && bus.mem_req && !bus.dmem_ready;
    timeout_hit = (state == MEM_WAIT) && !bus.dmem_ready &&
                  (wait_cnt == TIMEOUT_CNT);

    case (state)
      INIT: state_next = RUN;
      RUN: begin
        if (mem_stall) begin
          state_next = MEM_WAIT;
        end else begin
          en             = run_en;
          flush          = run_flush;
          bubble         = run_bubble;
          redirect_flush = bus.ex_redirect;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) begin
          en             = run_en;
          flush          = run_flush;
          bubble         = run_bubble;
          redirect_flush = bus.ex_redirect;
          state_next     = RUN;
        end else if (timeout_hit) begin
          state_next = HALT;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= INIT;
    else         state <= state_next;
  end

  // The stall cycle spent in RUN counts as the first wait cycle; the counter
  // holds at TIMEOUT instead of wrapping.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wait_cnt      <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      if (mem_stall) begin
        wait_cnt <= WAIT_W'(1);
      end else if ((state == MEM_WAIT) && !bus.dmem_ready &&
                   (wait_cnt != TIMEOUT_CNT)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (timeout_hit) mem_timeout_q <= 1'b1;
    end
  end

  assign bus.pc_en        = en.pc;
  assign bus.if_id_en     = en.if_id;
  assign bus.id_ex_en     = en.id_ex;
  assign bus.ex_mem_en    = en.ex_mem;
  assign bus.mem_wb_en    = en.mem_wb;
  assign bus.if_id_flush  = flush;
  assign bus.id_ex_bubble = bubble;
  assign bus.halted       = (state == HALT);
  assign bus.mem_timeout  = mem_timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic stall_inc;
  assign stall_inc = ((state == RUN) || (state == MEM_WAIT)) && !en.pc;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_inc && !(&stall_cycles))
        stall_cycles <= stall_cycles + PERF_W'(1);
      if (redirect_flush && !(&flush_count))
        flush_count <= flush_count + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed self-checking bench for pipeline_ctrl built with
// TIMEOUT=4. Inputs change just after the falling edge and outputs are
// compared 1 time unit later, well away from the rising edge.
// Output vector layout for comparisons:
//   {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//    if_id_flush, id_ex_bubble, halted, mem_timeout}
// Define PIPE_CTRL_PERF_EN to also compare the performance counters.
module tb_pipeline_ctrl;

  localparam logic [8:0] V_FRZ  = 9'b00000_0000;
  localparam logic [8:0] V_RUN  = 9'b11111_0000;
  localparam logic [8:0] V_LU   = 9'b00111_0100;
  localparam logic [8:0] V_RED  = 9'b11111_1100;
  localparam logic [8:0] V_MISS = 9'b01111_1000;
  localparam logic [8:0] V_HALT = 9'b00000_0011;

  logic clk = 1'b0;
  logic arst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  pipeline_ctrl_if #(.REG_ADDR_W(5)) bus ();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  pipeline_ctrl #(
    .REG_ADDR_W (5),
    .TIMEOUT    (4),
    .PERF_W     (32)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .bus          (bus)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic memread,
                               input logic redirect, input logic imem_rdy,
                               input logic mreq, input logic dmem_rdy);
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.ex_rd       = rd;
    bus.ex_memread  = memread;
    bus.ex_redirect = redirect;
    bus.imem_ready  = imem_rdy;
    bus.mem_req     = mreq;
    bus.dmem_ready  = dmem_rdy;
  endtask

  task automatic idle();
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic checkOutput(input string tag, input logic [8:0] expv);
    logic [8:0] obs;
    #1;
    obs = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
           bus.if_id_flush, bus.id_ex_bubble, bus.halted, bus.mem_timeout};
    n_cmp++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic checkPerf(input string tag, input logic [31:0] exp_stall,
                           input logic [31:0] exp_flush);
    n_cmp++;
    assert (stall_cycles === exp_stall)
    else begin
      n_fail++;
      $error("[TB] FAIL %s.stall_cycles: observed %0d expected %0d",
             tag, stall_cycles, exp_stall);
    end
    n_cmp++;
    assert (flush_count === exp_flush)
    else begin
      n_fail++;
      $error("[TB] FAIL %s.flush_count: observed %0d expected %0d",
             tag, flush_count, exp_flush);
    end
  endtask
`endif

  task automatic nextCycle();
    @(negedge clk);
  endtask

  initial begin
    arst_n = 1'b1;
    idle();
    #2 arst_n = 1'b0;
    checkOutput("reset_state", V_FRZ);

    // Release: exactly one INIT cycle, then everything runs.
    nextCycle(); arst_n = 1'b1;
    checkOutput("init_cycle", V_FRZ);
    nextCycle();
    checkOutput("run_idle", V_RUN);

    // Load-use hazards on rs2 and rs1, and cases that must not stall.
    nextCycle(); applyStimulus(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("load_use_rs2", V_LU);
    nextCycle(); applyStimulus(5'd1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("load_use_done", V_RUN);
    nextCycle(); applyStimulus(5'd3, 5'd7, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("load_use_rs1", V_LU);
    nextCycle(); applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("rd_zero_no_stall", V_RUN);
    nextCycle(); applyStimulus(5'd4, 5'd4, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("no_reg_match", V_RUN);

    // Priority among redirect, load-use and fetch miss.
    nextCycle(); applyStimulus(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("redirect_over_load_use", V_RED);
    nextCycle(); applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("fetch_miss", V_MISS);
    nextCycle(); applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("redirect_over_miss", V_RED);
    nextCycle(); applyStimulus(5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("load_use_over_miss", V_LU);

    // Fresh reset so the performance counters start from zero.
    nextCycle(); arst_n = 1'b0; idle();
    checkOutput("reset_pulse", V_FRZ);
    nextCycle(); arst_n = 1'b1;
    nextCycle();
    checkOutput("run_after_reset", V_RUN);

    nextCycle(); applyStimulus(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("redirect_counted", V_RED);

    // Memory stall of three frozen cycles; a redirect arriving with the stall
    // must not flush.
    nextCycle(); applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("mem_stall_run", V_FRZ);
    nextCycle(); applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("mem_wait_1", V_FRZ);
    nextCycle();
    checkOutput("mem_wait_2", V_FRZ);
    nextCycle(); applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("mem_release", V_RUN);
    nextCycle(); idle();
    checkOutput("run_after_mem", V_RUN);
`ifdef PIPE_CTRL_PERF_EN
    checkPerf("after_mem_wait", 32'd3, 32'd1);
`endif

    // Release from MEM_WAIT takes the fetch-miss path.
    nextCycle(); applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("mem_stall2", V_FRZ);
    nextCycle(); applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mem_release_miss", V_MISS);
    nextCycle(); idle();
    checkOutput("run_after_mem2", V_RUN);
`ifdef PIPE_CTRL_PERF_EN
    checkPerf("after_mem_wait2", 32'd5, 32'd1);
`endif

    // Timeout with TIMEOUT=4: RUN stall loads 1, MEM_WAIT counts 1..4, HALT.
    nextCycle(); applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("to_run_stall", V_FRZ);
    for (int i = 1; i <= 3; i++) begin
      nextCycle();
      checkOutput($sformatf("to_wait_%0d", i), V_FRZ);
    end
    nextCycle();
    checkOutput("to_last_wait", V_FRZ);
    nextCycle();
    checkOutput("halt_entered", V_HALT);
    nextCycle(); idle();
    checkOutput("halt_held", V_HALT);

    // Asynchronous reset mid-cycle clears HALT and the sticky flag at once.
    #2 arst_n = 1'b0;
    checkOutput("reset_from_halt", V_FRZ);
`ifdef PIPE_CTRL_PERF_EN
    checkPerf("reset_from_halt", 32'd0, 32'd0);
`endif
    nextCycle(); arst_n = 1'b1;
    nextCycle();
    checkOutput("run_after_halt_reset", V_RUN);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
